game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the HEROE board. Conditions the four push-buttons and runs the master state machine whose state code drives the 8-digit display multiplexer's `presente` input. Also owns the hero selection index, the welcome and result screen timeouts, and the run/score-clear strobes consumed by the obstacle and score logic.

## Interface
Parameters:
- `TICK_DIV`, default 27_000_000: clk cycles per one-second tick.
- `WLCM_SEC`, default 3: welcome screen duration in seconds, ≥1.
- `WL_SEC`, default 5: win/lose screen duration in seconds, ≥1.
- `DEB_CYCLES`, default 270_000: stable cycles required to accept a button level.
- `NUM_HEROES`, default 3: number of selectable heroes, 2..4.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `btn_power` in 1: raw, asynchronous, active-high button.
- `btn_start` in 1: raw, asynchronous, active-high button.
- `btn_pause` in 1: raw, asynchronous, active-high button.
- `btn_sel` in 1: raw, asynchronous, active-high button.
- `colision` in 1: one-cycle pulse, `clk` domain, hero hit an obstacle.
- `win` in 1: one-cycle pulse, `clk` domain, winning score reached.
- `presente` out 3: state code for the display: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5.
- `heroe_sel` out 2: selected hero index, 0..NUM_HEROES-1.
- `resultado` out 1: 1 = last game won, 0 = lost. Valid in WL.
- `game_run` out 1: high only in GAME; enables obstacle and score advance.
- `clear_score` out 1: one-cycle pulse on the CH→GAME transition.

## Operation
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Stable-level counter. The accepted level updates only after the synced level has differed from it for DEB_CYCLES consecutive cycles.
  - Accepted 0→1 edge produces a one-cycle press pulse.
- FSM transitions (evaluated on press pulses and input pulses):
  - Power press in any state other than OFF → OFF. This has the highest priority.
  - OFF: power press → WLCM.
  - WLCM: start press, or WLCM_SEC timeout → CH.
  - CH: sel press → `heroe_sel` increments, wrapping NUM_HEROES-1→0. Start press → GAME and pulses `clear_score`.
  - GAME: priority is `colision` → WL with `resultado`=0, then `win` → WL with `resultado`=1, then pause press → PA.
  - PA: pause press → GAME. Start press → CH (abort game).
  - WL: start press → CH. WL_SEC timeout → WLCM.
- Inputs that have no transition in the current state are ignored. This includes `colision`/`win` outside GAME and sel outside CH.
- Simultaneous press pulses in one cycle: power > start > pause > sel.
- `heroe_sel` and `resultado` hold their values across all states. Only reset changes them, apart from the transitions above.
- Timer: prescaler 0..TICK_DIV-1 plus a seconds counter. Both clear on every state entry and count only in WLCM and WL.

## Timing
- Reset values: `presente`=OFF, `heroe_sel`=0, `resultado`=0, `game_run`=0, `clear_score`=0. Debounce accepted levels=0. Timers=0.
- Reset is asynchronous mid-game: outputs go to reset values immediately, with no completion of the current state.
- A button held through reset release yields exactly one press, after sync plus debounce.
- Press latency: raw rise to press pulse is 2 + DEB_CYCLES cycles, ±1. `presente` updates on the next edge.
- `colision`/`win` to `presente`=WL: 1 cycle. `game_run` falls on the same edge.
- Timeouts: `presente` leaves WLCM exactly WLCM_SEC×TICK_DIV cycles after the entry edge. Same rule for WL with WL_SEC.
- A press on the exact timeout cycle takes priority: start in WL → CH.
- Glitches shorter than DEB_CYCLES produce no press.
- `clear_score` is high in the same cycle that `presente` first reads GAME.

## Structure
- Shared header `game_defs.vh`: state encodings OFF..PA. The display multiplexer must use the same codes.
- Sub-module `btn_cond` (synchronizer, debounce, edge pulse; parameter DEB_CYCLES), instantiated four times.
- FSM and timer stay inside `game_ctrl`.

## Test plan
All scenarios use TICK_DIV=10, WLCM_SEC=2, WL_SEC=3, DEB_CYCLES=4.
- Power-up: reset, then press power → `presente` 0→1. With no input, `presente`=2 exactly 20 cycles after WLCM entry.
- Hero select: in CH, press sel 4 times → `heroe_sel` 1,2,0,1.
- Game start: press start in CH → `presente`=3, one-cycle `clear_score`, `game_run`=1.
- Pause: in GAME, pause → 5 with `game_run`=0. Pause again → 3. In PA, start → 2.
- Result priority: same-cycle `colision` and `win` in GAME → `presente`=4, `resultado`=0. Then 30 idle cycles → `presente`=1.
- Bounce: a 3-cycle glitch on start → no transition. Power press mid-GAME → 0. Async `rst` asserted mid-WLCM → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared state encodings for the game sequencer and the display multiplexer.
// Any block decoding `presente` must import these codes rather than redefine them.
package game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_WLCM = 3'd1,
      ST_CH   = 3'd2,
      ST_GAME = 3'd3,
      ST_WL   = 3'd4,
      ST_PA   = 3'd5
   } state_t;

   localparam int BTN_POWER = 0;
   localparam int BTN_START = 1;
   localparam int BTN_PAUSE = 2;
   localparam int BTN_SEL   = 3;
   localparam int NUM_BTNS  = 4;

endpackage

// File: rtl/game_ctrl_btn_cond.sv
// Push-button conditioner: two-flop synchronizer, stable-level debounce and
// a one-cycle pulse on each accepted rising level.
module btn_cond #(
   parameter int DEB_CYCLES = 270_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic [CW-1:0] cnt_reg;

   // The counter only runs while the synced level disagrees with the accepted
   // level; any return to agreement restarts the stability window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
         press     <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         press     <= 1'b0;
         if (sync2_reg != level_reg) begin
            if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
               level_reg <= sync2_reg;
               cnt_reg   <= '0;
               press     <= sync2_reg;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Master game sequencer: conditions the four buttons, runs the game state
// machine and the welcome/result screen timers, and drives the display state code.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int TICK_DIV   = 27_000_000,
   parameter int WLCM_SEC   = 3,
   parameter int WL_SEC     = 5,
   parameter int DEB_CYCLES = 270_000,
   parameter int NUM_HEROES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_power,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       btn_sel,
   input  logic       colision,
   input  logic       win,
   output logic [2:0] presente,
   output logic [1:0] heroe_sel,
   output logic       resultado,
   output logic       game_run,
   output logic       clear_score
);

   localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MAX_SEC = (WLCM_SEC > WL_SEC) ? WLCM_SEC : WL_SEC;
   localparam int SW      = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

   logic [NUM_BTNS-1:0] raw;
   logic [NUM_BTNS-1:0] press;

   assign raw[BTN_POWER] = btn_power;
   assign raw[BTN_START] = btn_start;
   assign raw[BTN_PAUSE] = btn_pause;
   assign raw[BTN_SEL]   = btn_sel;

   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
         btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_cond (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[gi]),
            .press (press[gi])
         );
      end
   endgenerate

   state_t      state_reg;
   state_t      state_next;
   logic [1:0]  heroe_reg;
   logic [1:0]  heroe_next;
   logic        resultado_reg;
   logic        resultado_next;
   logic        game_run_reg;
   logic        clear_score_reg;
   logic [PW-1:0] presc_reg;
   logic [SW-1:0] sec_reg;
   logic        tick_end;
   logic        timeout;

   assign tick_end = (presc_reg == PW'(TICK_DIV - 1));
   assign timeout  = tick_end &&
                     (sec_reg == ((state_reg == ST_WL) ? SW'(WL_SEC - 1) : SW'(WLCM_SEC - 1)));

   // Power overrides everything; within a state the if-chain order gives
   // start > pause > sel, and colision > win > pause in GAME.
   always_comb begin
      state_next     = state_reg;
      heroe_next     = heroe_reg;
      resultado_next = resultado_reg;
      if (press[BTN_POWER] && state_reg != ST_OFF) begin
         state_next = ST_OFF;
      end else begin
         case (state_reg)
            ST_OFF:  if (press[BTN_POWER]) state_next = ST_WLCM;
            ST_WLCM: if (press[BTN_START] || timeout) state_next = ST_CH;
            ST_CH: begin
               if (press[BTN_START]) begin
                  state_next = ST_GAME;
               end else if (press[BTN_SEL]) begin
                  heroe_next = (heroe_reg == 2'(NUM_HEROES - 1)) ? 2'd0 : heroe_reg + 2'd1;
               end
            end
            ST_GAME: begin
               if (colision) begin
                  state_next     = ST_WL;
                  resultado_next = 1'b0;
               end else if (win) begin
                  state_next     = ST_WL;
                  resultado_next = 1'b1;
               end else if (press[BTN_PAUSE]) begin
                  state_next = ST_PA;
               end
            end
            ST_PA: begin
               if (press[BTN_START])      state_next = ST_CH;
               else if (press[BTN_PAUSE]) state_next = ST_GAME;
            end
            ST_WL: begin
               if (press[BTN_START]) state_next = ST_CH;
               else if (timeout)     state_next = ST_WLCM;
            end
            default: state_next = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_OFF;
         heroe_reg       <= 2'd0;
         resultado_reg   <= 1'b0;
         game_run_reg    <= 1'b0;
         clear_score_reg <= 1'b0;
         presc_reg       <= '0;
         sec_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         heroe_reg       <= heroe_next;
         resultado_reg   <= resultado_next;
         game_run_reg    <= (state_next == ST_GAME);
         clear_score_reg <= (state_reg == ST_CH) && (state_next == ST_GAME);
         // Timers restart on every state change so each screen gets a full period.
         if (state_next != state_reg) begin
            presc_reg <= '0;
            sec_reg   <= '0;
         end else if (state_reg == ST_WLCM || state_reg == ST_WL) begin
            if (tick_end) begin
               presc_reg <= '0;
               sec_reg   <= sec_reg + 1'b1;
            end else begin
               presc_reg <= presc_reg + 1'b1;
            end
         end
      end
   end

   assign presente    = state_reg;
   assign heroe_sel   = heroe_reg;
   assign resultado   = resultado_reg;
   assign game_run    = game_run_reg;
   assign clear_score = clear_score_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: table of game steps with a scoreboard of
// expected outputs, plus hand sequences for timeout, reset and debounce corners.
module tb_game_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_power = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_pause = 1'b0;
   logic       btn_sel = 1'b0;
   logic       colision = 1'b0;
   logic       win = 1'b0;
   logic [2:0] presente;
   logic [1:0] heroe_sel;
   logic       resultado;
   logic       game_run;
   logic       clear_score;

   int tests = 0;
   int failed = 0;
   int clr_cnt = 0;

   game_ctrl #(
      .TICK_DIV(10), .WLCM_SEC(2), .WL_SEC(3), .DEB_CYCLES(4), .NUM_HEROES(3)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_power(btn_power), .btn_start(btn_start),
      .btn_pause(btn_pause), .btn_sel(btn_sel),
      .colision(colision), .win(win),
      .presente(presente), .heroe_sel(heroe_sel), .resultado(resultado),
      .game_run(game_run), .clear_score(clear_score)
   );

   always #5 clk = ~clk;

   typedef enum int {A_POWER, A_START, A_PAUSE, A_SEL, A_COL, A_WIN, A_COLWIN, A_IDLE, A_GLITCH} act_t;

   typedef struct {
      act_t       act;
      int         n;
      logic [2:0] pres;
      logic [1:0] hero;
      logic       res;
      logic       run;
      int         clr;
   } vec_t;

   typedef struct {
      logic [2:0] pres;
      logic [1:0] hero;
      logic       res;
      logic       run;
      int         clr;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // clear_score must only ever appear in the first GAME cycle.
   always @(negedge clk) begin
      if (clear_score === 1'b1) begin
         clr_cnt++;
         chk("clear_in_game", 32'(presente), 32'd3);
      end
   end

   task automatic set_btn(input act_t a, input logic v);
      case (a)
         A_POWER: btn_power = v;
         A_START: btn_start = v;
         A_PAUSE: btn_pause = v;
         default: btn_sel = v;
      endcase
   endtask

   task automatic do_act(input act_t a, input int n);
      case (a)
         A_POWER, A_START, A_PAUSE, A_SEL: begin
            set_btn(a, 1'b1);
            repeat (10) @(negedge clk);
            set_btn(a, 1'b0);
            repeat (10) @(negedge clk);
         end
         A_COL: begin
            colision = 1'b1; @(negedge clk); colision = 1'b0;
         end
         A_WIN: begin
            win = 1'b1; @(negedge clk); win = 1'b0;
         end
         A_COLWIN: begin
            colision = 1'b1; win = 1'b1; @(negedge clk);
            colision = 1'b0; win = 1'b0;
         end
         A_GLITCH: begin
            btn_start = 1'b1;
            repeat (3) @(negedge clk);
            btn_start = 1'b0;
            repeat (17) @(negedge clk);
         end
         default: repeat (n) @(negedge clk);
      endcase
   endtask

   function automatic vec_t mk(act_t a, int n, int p, int h, int r, int g, int c);
      vec_t v;
      v.act = a; v.n = n; v.pres = 3'(p); v.hero = 2'(h);
      v.res = 1'(r); v.run = 1'(g); v.clr = c;
      return v;
   endfunction

   initial begin
      bit   found;
      exp_t e;
      int   clr_start;

      // action, n, presente, heroe_sel, resultado, game_run, clear pulses
      vecs.push_back(mk(A_SEL,    0, 2, 1, 0, 0, 0));
      vecs.push_back(mk(A_SEL,    0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(A_SEL,    0, 2, 0, 0, 0, 0));
      vecs.push_back(mk(A_SEL,    0, 2, 1, 0, 0, 0));
      vecs.push_back(mk(A_START,  0, 3, 1, 0, 1, 1));
      vecs.push_back(mk(A_PAUSE,  0, 5, 1, 0, 0, 0));
      vecs.push_back(mk(A_PAUSE,  0, 3, 1, 0, 1, 0));
      vecs.push_back(mk(A_PAUSE,  0, 5, 1, 0, 0, 0));
      vecs.push_back(mk(A_START,  0, 2, 1, 0, 0, 0));
      vecs.push_back(mk(A_START,  0, 3, 1, 0, 1, 1));
      vecs.push_back(mk(A_COLWIN, 0, 4, 1, 0, 0, 0));
      vecs.push_back(mk(A_IDLE,  29, 4, 1, 0, 0, 0));
      vecs.push_back(mk(A_IDLE,   1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(A_START,  0, 2, 1, 0, 0, 0));
      vecs.push_back(mk(A_START,  0, 3, 1, 0, 1, 1));
      vecs.push_back(mk(A_WIN,    0, 4, 1, 1, 0, 0));
      vecs.push_back(mk(A_START,  0, 2, 1, 1, 0, 0));
      vecs.push_back(mk(A_START,  0, 3, 1, 1, 1, 1));
      vecs.push_back(mk(A_POWER,  0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(A_POWER,  0, 1, 1, 1, 0, 0));
      vecs.push_back(mk(A_IDLE,  10, 2, 1, 1, 0, 0));
      vecs.push_back(mk(A_GLITCH, 0, 2, 1, 1, 0, 0));
      vecs.push_back(mk(A_SEL,    0, 2, 2, 1, 0, 0));
      vecs.push_back(mk(A_POWER,  0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(A_POWER,  0, 1, 2, 1, 0, 0));

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_presente",  32'(presente),    32'd0);
      chk("rst_heroe",     32'(heroe_sel),   32'd0);
      chk("rst_resultado", 32'(resultado),   32'd0);
      chk("rst_game_run",  32'(game_run),    32'd0);
      chk("rst_clear",     32'(clear_score), 32'd0);
      $display("[TB] reset: presente=%0d heroe=%0d", presente, heroe_sel);

      // Power-up and exact WLCM timeout.
      btn_power = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (presente == 3'd1) found = 1'b1;
      end
      chk("wlcm_entry", 32'(found), 32'd1);
      repeat (19) @(negedge clk);
      chk("wlcm_before_timeout", 32'(presente), 32'd1);
      @(negedge clk);
      chk("wlcm_timeout", 32'(presente), 32'd2);
      btn_power = 1'b0;
      repeat (10) @(negedge clk);
      $display("[TB] power-up: presente=%0d after WLCM timeout", presente);

      for (int i = 0; i < vecs.size(); i++) begin
         e.pres = vecs[i].pres; e.hero = vecs[i].hero; e.res = vecs[i].res;
         e.run = vecs[i].run; e.clr = vecs[i].clr;
         sb.push_back(e);
         clr_start = clr_cnt;
         do_act(vecs[i].act, vecs[i].n);
         e = sb.pop_front();
         chk($sformatf("vec%0d_presente", i),  32'(presente),  32'(e.pres));
         chk($sformatf("vec%0d_heroe", i),     32'(heroe_sel), 32'(e.hero));
         chk($sformatf("vec%0d_resultado", i), 32'(resultado), 32'(e.res));
         chk($sformatf("vec%0d_game_run", i),  32'(game_run),  32'(e.run));
         chk($sformatf("vec%0d_clear", i),     32'(clr_cnt - clr_start), 32'(e.clr));
         $display("[TB] vec %0d act=%0d presente=%0d heroe=%0d res=%0d run=%0d",
                  i, vecs[i].act, presente, heroe_sel, resultado, game_run);
      end

      // Asynchronous reset mid-WLCM: outputs clear before any clock edge.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_presente",  32'(presente),    32'd0);
      chk("async_heroe",     32'(heroe_sel),   32'd0);
      chk("async_resultado", 32'(resultado),   32'd0);
      chk("async_game_run",  32'(game_run),    32'd0);
      chk("async_clear",     32'(clear_score), 32'd0);
      $display("[TB] async reset: presente=%0d heroe=%0d res=%0d", presente, heroe_sel, resultado);

      // Power held through reset release gives one press only.
      btn_power = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("held_power_press", 32'(presente), 32'd1);
      repeat (25) @(negedge clk);
      chk("held_power_single", 32'(presente), 32'd2);
      btn_power = 1'b0;
      repeat (10) @(negedge clk);
      $display("[TB] held power: presente=%0d", presente);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
